// File: rtl/adc_rx_pkg.sv
// Shared types and constants for the serial ADC receiver: capture FSM
// states, frame timing and the channel-index width helper.
package adc_rx_pkg;

  localparam int FRAME_CYCLES = 20;
  localparam int DEF_N_CH     = 8;
  localparam int DEF_ADC_BITS = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cap_state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_rx_out_buf.sv
// Single-frame output buffer: holds one word per channel and streams them
// out channel-sequentially with a registered valid/ready interface.
module adc_rx_out_buf
  import adc_rx_pkg::*;
#(
  parameter  int N_CH     = DEF_N_CH,
  parameter  int ADC_BITS = DEF_ADC_BITS,
  localparam int CH_W     = chan_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic [N_CH*ADC_BITS-1:0] i_words,
  input  logic                     i_ready,
  output logic                     o_can_accept,
  output logic                     o_valid,
  output logic [ADC_BITS-1:0]      o_data,
  output logic [CH_W-1:0]          o_chan,
  output logic                     o_last
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [ADC_BITS-1:0] r_hold [N_CH];
  logic [ADC_BITS-1:0] r_data;
  logic [CH_W-1:0]     r_chan;
  logic                r_full;
  logic                r_last;

  logic                w_xfer;
  logic                w_drain;
  logic [CH_W-1:0]     w_next_chan;

  assign w_xfer      = r_full & i_ready;
  assign w_drain     = w_xfer & r_last;
  assign w_next_chan = r_chan + 1'b1;
  // A frame finishing its last handshake frees the buffer on that same edge.
  assign o_can_accept = ~r_full | w_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_last <= 1'b0;
      r_chan <= '0;
      r_data <= '0;
      // NOTE: the hold array is reset so every output reads 0 until a frame lands.
      for (int i = 0; i < N_CH; i++) r_hold[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < N_CH; i++) r_hold[i] <= i_words[i*ADC_BITS +: ADC_BITS];
      r_full <= 1'b1;
      r_last <= 1'b0;
      r_chan <= '0;
      r_data <= i_words[ADC_BITS-1:0];
    end else if (w_drain) begin
      r_full <= 1'b0;
      r_last <= 1'b0;
      r_chan <= '0;
    end else if (w_xfer) begin
      r_chan <= w_next_chan;
      r_data <= r_hold[w_next_chan];
      r_last <= (w_next_chan == LAST_CH);
    end
  end

  assign o_valid = r_full;
  assign o_data  = r_data;
  assign o_chan  = r_chan;
  assign o_last  = r_last;

endmodule

// File: rtl/adc_serial_rx.sv
// Frame-aligned deserialiser for N_CH serial ADC lines. Optional build macro
// ADC_SERIAL_RX_TEST_PATTERN_EN adds test_mode to substitute a counter pattern.
module adc_serial_rx
  import adc_rx_pkg::*;
#(
  parameter  int N_CH     = DEF_N_CH,
  parameter  int ADC_BITS = DEF_ADC_BITS,
  parameter  int CNT_W    = 32,
  localparam int CH_W     = chan_w(N_CH)
) (
  input  logic                data_clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                adc_word_sync,
  input  logic [N_CH-1:0]     adc_sdata,
  input  logic                clr_flags,
`ifdef ADC_SERIAL_RX_TEST_PATTERN_EN
  input  logic                test_mode,
`endif
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADC_BITS-1:0] m_data,
  output logic [CH_W-1:0]     m_chan,
  output logic                m_last,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                overrun,
  output logic                sync_err,
  output logic                busy
);

  localparam int              BIT_W    = $clog2(ADC_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ADC_BITS - 1);

  cap_state_t          r_state, w_next_state;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [ADC_BITS-1:0] r_shift [N_CH];
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_overrun, r_sync_err;

  logic w_sample, w_bit_clr, w_done, w_sync_err_set;
  logic w_can_accept, w_load, w_overrun_set;
  logic [N_CH*ADC_BITS-1:0] w_hold_in;

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state   = r_state;
    w_sample       = 1'b0;
    w_bit_clr      = 1'b0;
    w_done         = 1'b0;
    w_sync_err_set = 1'b0;
    unique case (r_state)
      IDLE: if (adc_word_sync && enable) begin
        w_next_state = SHIFT;
        w_bit_clr    = 1'b1;
      end
      SHIFT: if (adc_word_sync) begin
        w_sync_err_set = 1'b1;
        if (enable) w_bit_clr    = 1'b1;
        else        w_next_state = IDLE;
      end else begin
        w_sample = 1'b1;
        if (r_bit_cnt == LAST_BIT) w_next_state = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (adc_word_sync && enable) begin
          w_next_state = SHIFT;
          w_bit_clr    = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_load        = w_done & w_can_accept;
  assign w_overrun_set = w_done & ~w_can_accept;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
      r_sync_err  <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_shift[i] <= '0;
    end else begin
      if (w_bit_clr)     r_bit_cnt <= '0;
      else if (w_sample) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_sample)
        for (int i = 0; i < N_CH; i++) r_shift[i] <= {r_shift[i][ADC_BITS-2:0], adc_sdata[i]};
      if (w_load) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_overrun_set)  r_overrun  <= 1'b1;
      else if (clr_flags) r_overrun  <= 1'b0;
      if (w_sync_err_set) r_sync_err <= 1'b1;
      else if (clr_flags) r_sync_err <= 1'b0;
    end
  end

  always_comb begin
    w_hold_in = '0;
    for (int i = 0; i < N_CH; i++) begin
`ifdef ADC_SERIAL_RX_TEST_PATTERN_EN
      // Pattern word tags the pre-increment frame count with the channel index.
      w_hold_in[i*ADC_BITS +: ADC_BITS] = test_mode ?
          {r_frame_cnt[ADC_BITS-1-CH_W:0], CH_W'(i)} : r_shift[i];
`else
      w_hold_in[i*ADC_BITS +: ADC_BITS] = r_shift[i];
`endif
    end
  end

  adc_rx_out_buf #(
    .N_CH     (N_CH),
    .ADC_BITS (ADC_BITS)
  ) u_out_buf (
    .clk          (data_clk),
    .rst_n        (reset_n),
    .i_load       (w_load),
    .i_words      (w_hold_in),
    .i_ready      (m_ready),
    .o_can_accept (w_can_accept),
    .o_valid      (m_valid),
    .o_data       (m_data),
    .o_chan       (m_chan),
    .o_last       (m_last)
  );

  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;
  assign sync_err  = r_sync_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Receives serial conversion results from N_CH ADC data lines on the 40 MHz data_clk.
- Frames are aligned to the adc_word_sync pulse that the system clock block drives to the ADCs.
- Deserialises one ADC_BITS word per line per 2 MSPS frame and hands the words out as a channel-sequential stream.
- Sits between the ADC LVDS input buffers and the XDMA stream packer.

Parameters:
- N_CH, 8: number of serial ADC data lines, 2..32.
- ADC_BITS, 18: bits per conversion, MSB first, 8..24.
- CNT_W, 32: width of the delivered-frame counter.

Ports:
- data_clk  in  1  40 MHz capture clock; the only clock.
- reset_n  in  1  async active-low reset. Asserted asynchronously, released synchronously to data_clk upstream.
- enable  in  1  allows new frames to start.
- adc_word_sync  in  1  one-cycle frame-alignment pulse, 20-cycle period.
- adc_sdata  in  N_CH  serial data, bit i = channel i.
- clr_flags  in  1  one-cycle clear of the sticky flags.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  ADC_BITS  sample word.
- m_chan  out  $clog2(N_CH)  channel index of m_data.
- m_last  out  1  high with channel N_CH-1.
- frame_cnt  out  CNT_W  frames delivered, wraps to 0.
- overrun  out  1  sticky: completed frame dropped because the output buffer was busy.
- sync_err  out  1  sticky: adc_word_sync seen mid-capture.
- busy  out  1  capture FSM not IDLE.

Behaviour:
- Reset: every output is 0. Shift registers, hold registers and the bit counter are cleared. FSM goes to IDLE.
- Capture FSM states:
  - IDLE -> SHIFT on an edge where adc_word_sync=1 and enable=1. The bit counter is loaded with 0.
  - SHIFT: on each of the next ADC_BITS edges, each channel's shift register shifts left and takes adc_sdata[i] into the LSB. The first sampled bit is the MSB.
  - SHIFT -> DONE on the edge sampling bit ADC_BITS-1.
  - DONE (one cycle) -> IDLE. If the output buffer is empty, all shift registers are copied to the hold registers and frame_cnt increments. Otherwise the frame is discarded and overrun is set.
- Sync during capture: adc_word_sync=1 while in SHIFT restarts capture at bit 0, discards the partial frame and sets sync_err. If enable=0 at that edge, the FSM returns to IDLE instead.
- Sync during DONE: adc_word_sync=1 in DONE is honoured. DONE completes its transfer and the FSM goes directly to SHIFT.
- enable only gates frame start. Deasserting enable mid-frame lets the current frame complete.
- Output sequencer:
  - Becomes non-empty on the DONE edge. m_valid=1, m_chan=0, m_data=hold[0] are registered outputs valid from that edge.
  - Each m_valid&m_ready handshake advances m_chan.
  - The handshake at m_chan=N_CH-1, where m_last=1, empties the buffer. m_valid drops unless a DONE occurs on the same edge.
  - If the buffer empties and DONE occurs on the same edge, the new frame is accepted: no overrun, and m_valid stays 1 with m_chan=0.
- Stream rules:
  - m_data, m_chan and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never depends combinationally on m_ready.
- Drain timing: with m_ready held at 1, a frame drains in N_CH cycles. N_CH ≤ 20 therefore never overruns at 2 MSPS.
- Flags:
  - overrun and sync_err stay set until clr_flags.
  - If clr_flags and a set condition occur on the same edge, set wins.
- frame_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Latency: last data bit sampled at edge E; word 0 is visible after edge E+1.

Optional Feature:
- Macro ADC_SERIAL_RX_TEST_PATTERN_EN.
- Defined: adds input test_mode.
  - When test_mode=1, DONE loads hold[i] = {frame_cnt[ADC_BITS-1-$clog2(N_CH):0], i} in place of the shifted data.
  - Capture timing and handshake are unchanged.
- Undefined: no test_mode port; hold registers always take the shifted data.

Decomposition:
- Package adc_rx_pkg:
  - capture FSM state enum (IDLE, SHIFT, DONE);
  - FRAME_CYCLES=20;
  - default ADC_BITS and N_CH localparams;
  - the function deriving the channel index width.
- Sub-module adc_rx_out_buf: hold registers, channel sequencer, valid/ready logic and overlap rule.
- The top level keeps the capture FSM, shift registers, counters and flags.

Test Plan:
- Defaults, m_ready=1, enable=1, sync every 20 cycles, channel i serialises 18'h3_0000+i → words 0x30000..0x30007 with m_chan 0..7, m_last on chan 7, word 0 one cycle after the last bit, frame_cnt=1 after the first frame.
- m_ready=0 for 25 cycles across a frame boundary → m_data stable for the whole frame, second frame dropped, overrun=1, frame_cnt unchanged; clr_flags → overrun=0.
- Extra adc_word_sync 7 cycles into SHIFT → sync_err=1, partial frame discarded, the frame captured from the extra sync delivers correct data.
- enable=0 before a sync → no capture, busy=0, m_valid=0; enable dropped mid-SHIFT → that frame still delivered.
- reset_n asserted mid-SHIFT with m_valid=1 → all outputs 0 immediately (asynchronous); first frame after release is correct with frame_cnt=1.
- ADC_SERIAL_RX_TEST_PATTERN_EN with test_mode=1, frame_cnt=5 → hold[3] = {5,3 in 3 bits} = 18'h2B.
